// File: rtl/mac_unit_pkg.sv
// Shared constants for the multiply-accumulate unit, so engine-level
// instantiators can size their operand and accumulator buses consistently.
package mac_unit_pkg;

    localparam int MAC_A_W   = 16;
    localparam int MAC_B_W   = 16;
    localparam int MAC_ACC_W = 32;

endpackage

// File: rtl/mac_unit.sv
// Two-stage signed multiply-accumulate: a registered full-width product,
// then a wrapping accumulator that adds each valid product exactly once.
module mac_unit
    import mac_unit_pkg::*;
#(
    parameter int A_W   = MAC_A_W,
    parameter int B_W   = MAC_B_W,
    parameter int ACC_W = MAC_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   prod;
    logic                    prod_valid;
    logic signed [ACC_W-1:0] prod_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod       <= '0;
            prod_valid <= 1'b0;
        end else begin
            prod_valid <= enable;
            if (enable) begin
                prod <= a * b;
            end
        end
    end

    // Size cast of a signed value sign-extends to the accumulator width.
    assign prod_ext = ACC_W'(prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (prod_valid) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit: directed scenarios plus randomized traffic
// checked against a sum-of-accepted-products reference model.
module tb_mac_unit;

    localparam int A_W   = 16;
    localparam int B_W   = 16;
    localparam int ACC_W = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    enable;
    logic signed [A_W-1:0]   a;
    logic signed [B_W-1:0]   b;
    logic signed [ACC_W-1:0] acc;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    // Reference model: every accepted product with the edge it was accepted on.
    longint prod_q[$];
    int     edge_q[$];

    mac_unit #(
        .A_W   (A_W),
        .B_W   (B_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .a      (a),
        .b      (b),
        .acc    (acc)
    );

    always #5 clk = ~clk;

    // Result one edge after acceptance: sum of products accepted before this edge.
    function automatic logic signed [ACC_W-1:0] model_acc();
        longint s;
        s = 0;
        foreach (prod_q[i]) begin
            if (edge_q[i] < edge_no) s += prod_q[i];
        end
        return s[ACC_W-1:0];
    endfunction

    task automatic cycle(input logic en, input logic signed [A_W-1:0] av,
                         input logic signed [B_W-1:0] bv);
        enable = en;
        a      = av;
        b      = bv;
        if (en) begin
            prod_q.push_back(longint'(av) * longint'(bv));
            edge_q.push_back(edge_no + 1);
        end
        @(posedge clk);
        edge_no++;
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        #1 rst = 1'b1;
        prod_q.delete();
        edge_q.delete();
        @(posedge clk);
        edge_no++;
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b1, 16'sd7, 16'sd9);
        cycle(1'b1, 16'sd7, 16'sd9);
        cycle(1'b0, 16'sd0, 16'sd0);
        checks++;
        if (acc !== 32'sd126) begin
            errors++;
            $display("[TB] FAIL reset_pre acc=%0d expected=%0d", acc, 126);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (acc !== 32'sd0) begin
            errors++;
            $display("[TB] FAIL reset_async acc=%0d expected=0", acc);
        end
        prod_q.delete();
        edge_q.delete();
        enable = 1'b1;
        a = 16'sd50;
        b = 16'sd50;
        @(posedge clk);
        edge_no++;
        #1;
        checks++;
        if (acc !== 32'sd0) begin
            errors++;
            $display("[TB] FAIL reset_hold acc=%0d expected=0", acc);
        end
        enable = 1'b0;
        rst = 1'b0;
        cycle(1'b0, 16'sd0, 16'sd0);
        checks++;
        if (acc !== 32'sd0) begin
            errors++;
            $display("[TB] FAIL reset_release acc=%0d expected=0", acc);
        end
    endtask

    task automatic test_single();
        do_reset();
        cycle(1'b1, 16'sd3, -16'sd4);
        checks++;
        if (acc !== 32'sd0) begin
            errors++;
            $display("[TB] FAIL single_latency acc=%0d expected=0", acc);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 16'sd1000, 16'sd1000);
            checks++;
            if (acc !== -32'sd12) begin
                errors++;
                $display("[TB] FAIL single_hold[%0d] acc=%0d expected=-12", i, acc);
            end
        end
    endtask

    task automatic test_window();
        int av [9] = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
        int bv [9] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
        int ev [9] = '{-10, -30, -60, -60, -60, -60, 10, 90, 180};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 16'(av[i]), 16'(bv[i]));
            checks++;
            if (acc !== ((i == 0) ? 32'sd0 : 32'(ev[i-1]))) begin
                errors++;
                $display("[TB] FAIL window[%0d] acc=%0d expected=%0d", i, acc,
                         (i == 0) ? 0 : ev[i-1]);
            end
        end
        cycle(1'b0, 16'sd0, 16'sd0);
        checks++;
        if (acc !== 32'sd180) begin
            errors++;
            $display("[TB] FAIL window_final acc=%0d expected=180", acc);
        end
    endtask

    task automatic test_gapped();
        do_reset();
        cycle(1'b1, 16'sd5, 16'sd5);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, -16'sd300, 16'sd77);
            checks++;
            if (acc !== 32'sd25) begin
                errors++;
                $display("[TB] FAIL gap_hold[%0d] acc=%0d expected=25", i, acc);
            end
        end
        cycle(1'b1, 16'sd2, -16'sd7);
        cycle(1'b0, 16'sd0, 16'sd0);
        checks++;
        if (acc !== 32'sd11) begin
            errors++;
            $display("[TB] FAIL gap_final acc=%0d expected=11", acc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, -16'sd32768, -16'sd32768);
        cycle(1'b0, 16'sd0, 16'sd0);
        checks++;
        if (acc !== 32'hC000_0000) begin
            errors++;
            $display("[TB] FAIL wrap_three acc=%h expected=c0000000", acc);
        end
        cycle(1'b1, -16'sd32768, -16'sd32768);
        cycle(1'b0, 16'sd0, 16'sd0);
        checks++;
        if (acc !== 32'sd0) begin
            errors++;
            $display("[TB] FAIL wrap_four acc=%h expected=00000000", acc);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        cycle(1'b1, 16'sd100, 16'sd100);
        enable = 1'b0;
        #1 rst = 1'b1;
        prod_q.delete();
        edge_q.delete();
        @(posedge clk);
        edge_no++;
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 16'sd0, 16'sd0);
            checks++;
            if (acc !== 32'sd0) begin
                errors++;
                $display("[TB] FAIL midreset_discard[%0d] acc=%0d expected=0", i, acc);
            end
        end
        cycle(1'b1, 16'sd1, 16'sd1);
        cycle(1'b0, 16'sd0, 16'sd0);
        checks++;
        if (acc !== 32'sd1) begin
            errors++;
            $display("[TB] FAIL midreset_restart acc=%0d expected=1", acc);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom));
            checks++;
            if (acc !== model_acc()) begin
                errors++;
                $display("[TB] FAIL b2b[%0d] acc=%0d expected=%0d", i, acc, model_acc());
            end
        end
        cycle(1'b0, 16'sd0, 16'sd0);
        checks++;
        if (acc !== model_acc()) begin
            errors++;
            $display("[TB] FAIL b2b_drain acc=%0d expected=%0d", acc, model_acc());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            checks++;
            if (acc !== model_acc()) begin
                errors++;
                $display("[TB] FAIL random[%0d] acc=%0d expected=%0d", i, acc, model_acc());
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        a      = '0;
        b      = '0;
        #2;
        checks++;
        if (acc !== 32'sd0) begin
            errors++;
            $display("[TB] FAIL power_on_reset acc=%0d expected=0", acc);
        end
        @(posedge clk);
        edge_no++;
        #1 rst = 1'b0;
        test_reset();
        test_single();
        test_window();
        test_gapped();
        test_wrap();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_unit.md
MAC_UNIT -- requirements
Module: mac_unit

Interface
REQ-001 Parameter A_W, default 16, operand a width.
REQ-002 Parameter B_W, default 16, operand b width.
REQ-003 Parameter ACC_W, default 32, accumulator width; SHALL be at least A_W+B_W.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset/clear; asynchronous, active-high.
REQ-006 enable  input  1  marks a, b as a valid sample this cycle.
REQ-007 a  input  A_W  signed two's-complement operand.
REQ-008 b  input  B_W  signed two's-complement operand.
REQ-009 acc  output  ACC_W  signed running sum; registered output.

Function
REQ-010 The block SHALL be a two-stage pipeline: a product stage, then an accumulate stage.
REQ-011 Product stage: on each edge with enable=1, the block SHALL register p = a*b as a full signed product of A_W+B_W bits, and SHALL set a valid flag.
REQ-012 Product stage: on each edge with enable=0, the block SHALL clear the valid flag; the product register MAY hold its value.
REQ-013 Accumulate stage: on each edge with the valid flag set, the block SHALL update acc <= acc + sign_extend(p, ACC_W).
REQ-014 When the valid flag is clear, acc SHALL hold its value.
REQ-015 Latency: a sample accepted at edge N SHALL appear in acc after edge N+1; throughput is one sample per cycle.
REQ-016 Arithmetic: accumulation SHALL wrap modulo 2^ACC_W (two's complement), with no saturation and no overflow flag.
REQ-017 enable may toggle every cycle; gaps SHALL neither add anything nor lose any in-flight product.
REQ-018 Back-to-back enabled cycles SHALL each contribute exactly once.
REQ-019 An in-flight product SHALL complete when enable drops in the following cycle.
REQ-020 No input handshake or backpressure: every enabled cycle SHALL be consumed.
REQ-021 Operand values presented with enable=0 SHALL be ignored.

Reset
REQ-022 While rst=1, acc, the product register and the valid flag SHALL be 0, set immediately and independently of clk.
REQ-023 rst is the only clear mechanism; users SHALL pulse rst for at least one cycle between accumulation windows.
REQ-024 rst asserted mid-operation SHALL discard any in-flight product; after release, acc SHALL restart from 0.
REQ-025 Samples with enable=1 during the first edge after rst deasserts SHALL be accepted normally.

Structure
REQ-026 The default widths SHALL live as shared constants (MAC_A_W, MAC_B_W, MAC_ACC_W) in the project package, for use by cnn-engine-level instantiators.
REQ-027 The block SHALL be a single flat module with no sub-modules; the multiplier SHALL be inferred.

Verification
REQ-028 Reset: assert rst asynchronously between edges -> acc=0 at once, before the next edge.
REQ-029 Single sample: a=3, b=-4, enable for one cycle -> acc=-12 after the second edge, then holds -12 for 5 further idle cycles.
REQ-030 Convolution window: a=10,20,...,90 with b=-1,-1,-1,0,0,0,1,1,1, nine consecutive enabled cycles -> acc=180 two edges after the last sample, with intermediate values -10,-30,-60,-60,-60,-60,10,90,180.
REQ-031 Gapped enable: a=5,b=5 enabled, 3 idle cycles, a=2,b=-7 enabled -> acc goes 25, holds, then 11.
REQ-032 Wrap: a=-32768, b=-32768 for 3 cycles -> acc=-1073741824 (0xC0000000); a 4th cycle -> acc=0.
REQ-033 Mid-operation reset: enable a=100, b=100, pulse rst in the next cycle -> acc=0 and stays 0 (product discarded); a following a=1, b=1 sample -> acc=1.
